// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: serial HDLC transmit framer (flag, zero-stuffed LSB-first payload, optional FCS, flag; idle and abort patterns).
// Latency: a byte accepted in IDLE puts the first opening-flag bit on Tx the next cycle; after that, one line bit per Clk.
// Backpressure: one-byte holding register; Tx_DataReady drops while it is full, and after the Last byte until the frame ends.
//
// Ports: Clk/Rst (async active-low); TxEN enable; Tx_Data/Tx_DataValid/Tx_DataLast/Tx_DataReady byte handshake;
//        Tx_AbortFrame abort request; Tx registered line; Tx_ValidFrame frame-active; Tx_Done/Tx_Aborted/Tx_Underrun pulses.
// Build option: define HDLC_TX_FCS_EN to add the CRC-16 (poly 8005) FCS between the payload and the closing flag.
module hdlc_tx_framer #(
  parameter logic [7:0] FLAG  = 8'h7E,
  parameter logic [7:0] ABORT = 8'hFE
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TxEN,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_DataLast,
  output logic       Tx_DataReady,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_Aborted,
  output logic       Tx_Underrun
);

  // State names the section that the bit currently on Tx belongs to.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SFLAG = 3'd1,
    S_DATA  = 3'd2,
    S_FCS   = 3'd3,
    S_EFLAG = 3'd4,
    S_ABRT  = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;        // index of the bit on Tx within its section
  logic        r_tx, w_tx_nxt;
  logic [7:0]  r_byte, w_byte_nxt;      // byte being shifted out
  logic        r_cur_last, w_cur_last_nxt;
  logic [7:0]  r_hold, w_hold_nxt;
  logic        r_hold_vld, w_hold_vld_nxt;
  logic        r_hold_last, w_hold_last_nxt;
  logic        r_last_seen, w_last_seen_nxt;
  logic [2:0]  r_ones, w_ones_nxt;      // consecutive 1s driven in DATA/FCS
  logic        r_done, w_done_nxt;
  logic        r_aborted, w_aborted_nxt;
  logic        r_underrun, w_underrun_nxt;
  logic        r_alive;                 // keeps Tx_DataReady low while reset is held
`ifdef HDLC_TX_FCS_EN
  logic [15:0] r_crc, w_crc_nxt;
  logic        w_crc_upd;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = d ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction
`endif

  logic       w_xfer;
  logic       w_abort;
  logic       w_stuff;
  logic [2:0] w_idx;
  logic       w_bit;
  logic       w_bit_sent;

  assign Tx_DataReady = r_alive && TxEN && !r_hold_vld && !r_last_seen &&
                        (r_state == S_IDLE || r_state == S_SFLAG || r_state == S_DATA);
  assign w_xfer  = Tx_DataValid && Tx_DataReady;
  assign w_abort = Tx_AbortFrame || !TxEN;
  assign w_stuff = (r_ones == 3'd5);
  assign w_idx   = r_cnt[2:0] + 3'd1;

  assign Tx            = r_tx;
  assign Tx_ValidFrame = (r_state != S_IDLE);
  assign Tx_Done       = r_done;
  assign Tx_Aborted    = r_aborted;
  assign Tx_Underrun   = r_underrun;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tx_nxt        = 1'b1;
    w_byte_nxt      = r_byte;
    w_cur_last_nxt  = r_cur_last;
    w_hold_nxt      = r_hold;
    w_hold_vld_nxt  = r_hold_vld;
    w_hold_last_nxt = r_hold_last;
    w_last_seen_nxt = r_last_seen;
    w_ones_nxt      = r_ones;
    w_done_nxt      = 1'b0;
    w_aborted_nxt   = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_bit           = 1'b0;
    w_bit_sent      = 1'b0;
`ifdef HDLC_TX_FCS_EN
    w_crc_nxt       = r_crc;
    w_crc_upd       = 1'b0;
`endif

    if (w_xfer) begin
      w_hold_nxt      = Tx_Data;
      w_hold_vld_nxt  = 1'b1;
      w_hold_last_nxt = Tx_DataLast;
      if (Tx_DataLast) w_last_seen_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = S_SFLAG;
          w_cnt_nxt   = 4'd0;
          w_tx_nxt    = FLAG[0];
          w_ones_nxt  = 3'd0;
`ifdef HDLC_TX_FCS_EN
          w_crc_nxt   = 16'h0000;
`endif
        end
      end

      S_SFLAG: begin
        // Holding the stuff counter and CRC at zero here means DATA entry starts clean.
        w_ones_nxt = 3'd0;
`ifdef HDLC_TX_FCS_EN
        w_crc_nxt  = 16'h0000;
`endif
        if (w_abort) begin
          w_state_nxt = S_ABRT;
        end else if (r_cnt != 4'd7) begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_tx_nxt  = FLAG[w_idx];
        end else begin
          w_state_nxt    = S_DATA;
          w_cnt_nxt      = 4'd0;
          w_byte_nxt     = r_hold;
          w_cur_last_nxt = r_hold_last;
          w_hold_vld_nxt = 1'b0;
          w_bit          = r_hold[0];
          w_bit_sent     = 1'b1;
        end
      end

      S_DATA: begin
        if (w_abort) begin
          w_state_nxt = S_ABRT;
        end else if (w_stuff) begin
          // Stuffed zero: the shifter holds, so r_cnt still names the last data bit sent.
          w_tx_nxt   = 1'b0;
          w_ones_nxt = 3'd0;
        end else if (r_cnt != 4'd7) begin
          w_cnt_nxt  = r_cnt + 4'd1;
          w_bit      = r_byte[w_idx];
          w_bit_sent = 1'b1;
        end else if (r_cur_last) begin
          w_cnt_nxt = 4'd0;
`ifdef HDLC_TX_FCS_EN
          w_state_nxt = S_FCS;
          w_bit       = r_crc[15];
          w_bit_sent  = 1'b1;
          w_crc_nxt   = {r_crc[14:0], 1'b0};
`else
          w_state_nxt = S_EFLAG;
          w_tx_nxt    = FLAG[0];
`endif
        end else if (r_hold_vld) begin
          w_cnt_nxt      = 4'd0;
          w_byte_nxt     = r_hold;
          w_cur_last_nxt = r_hold_last;
          w_hold_vld_nxt = 1'b0;
          w_bit          = r_hold[0];
          w_bit_sent     = 1'b1;
        end else begin
          w_state_nxt    = S_ABRT;
          w_underrun_nxt = 1'b1;
        end
      end

`ifdef HDLC_TX_FCS_EN
      S_FCS: begin
        if (w_abort) begin
          w_state_nxt = S_ABRT;
        end else if (w_stuff) begin
          w_tx_nxt   = 1'b0;
          w_ones_nxt = 3'd0;
        end else if (r_cnt != 4'd15) begin
          w_cnt_nxt  = r_cnt + 4'd1;
          w_bit      = r_crc[15];
          w_bit_sent = 1'b1;
          w_crc_nxt  = {r_crc[14:0], 1'b0};
        end else begin
          w_state_nxt = S_EFLAG;
          w_cnt_nxt   = 4'd0;
          w_tx_nxt    = FLAG[0];
        end
      end
`endif

      S_EFLAG: begin
        if (r_cnt != 4'd7) begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_tx_nxt  = FLAG[w_idx];
        end else begin
          w_state_nxt     = S_IDLE;
          w_done_nxt      = 1'b1;
          w_last_seen_nxt = 1'b0;
        end
      end

      S_ABRT: begin
        if (r_cnt != 4'd7) begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_tx_nxt  = ABORT[w_idx];
        end else begin
          w_state_nxt     = S_IDLE;
          w_aborted_nxt   = 1'b1;
          w_last_seen_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Common entry into ABRT from any active state (abort request or underrun).
    if (r_state != S_ABRT && w_state_nxt == S_ABRT) begin
      w_cnt_nxt      = 4'd0;
      w_tx_nxt       = ABORT[0];
      w_hold_vld_nxt = 1'b0;
      w_ones_nxt     = 3'd0;
    end

    if (w_bit_sent) begin
      w_tx_nxt   = w_bit;
      w_ones_nxt = w_bit ? r_ones + 3'd1 : 3'd0;
`ifdef HDLC_TX_FCS_EN
      w_crc_upd  = (r_state == S_SFLAG) || (r_state == S_DATA && w_state_nxt == S_DATA);
`endif
    end

`ifdef HDLC_TX_FCS_EN
    if (w_crc_upd) w_crc_nxt = crc_step(r_crc, w_bit);
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_tx        <= 1'b1;
      r_byte      <= 8'h00;
      r_cur_last  <= 1'b0;
      r_hold      <= 8'h00;
      r_hold_vld  <= 1'b0;
      r_hold_last <= 1'b0;
      r_last_seen <= 1'b0;
      r_ones      <= 3'd0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_underrun  <= 1'b0;
      r_alive     <= 1'b0;
`ifdef HDLC_TX_FCS_EN
      r_crc       <= 16'h0000;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tx        <= w_tx_nxt;
      r_byte      <= w_byte_nxt;
      r_cur_last  <= w_cur_last_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
      r_hold_last <= w_hold_last_nxt;
      r_last_seen <= w_last_seen_nxt;
      r_ones      <= w_ones_nxt;
      r_done      <= w_done_nxt;
      r_aborted   <= w_aborted_nxt;
      r_underrun  <= w_underrun_nxt;
      r_alive     <= 1'b1;
`ifdef HDLC_TX_FCS_EN
      r_crc       <= w_crc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer: self-checking bench for hdlc_tx_framer.
// Reference model builds each expected line bit stream from the framing rules (flag, LSB-first payload, optional FCS, stuffing, flag).
// Covers reset state, table vectors, abort, underrun, TxEN drop, async reset mid-frame and randomized back-to-back frames.
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       TxEN;
  logic [7:0] Tx_Data;
  logic       Tx_DataValid;
  logic       Tx_DataLast;
  logic       Tx_DataReady;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_Done;
  logic       Tx_Aborted;
  logic       Tx_Underrun;

  int checks = 0;
  int errors = 0;

  bit          got_q[$];
  bit          exp_q[$];
  logic [7:0]  pay_q[$];
  int          d_cnt, a_cnt, u_cnt;

  typedef struct {
    int          n;      // payload bytes
    logic [31:0] bytes;  // byte i at [8*i +: 8]
    int          dlen;   // stuffed data bits expected after the opening flag
    logic [31:0] dbits;  // bit i = i-th stuffed data bit on the line
  } vec_t;

  vec_t tbl[5];

  always #5 Clk = ~Clk;

  hdlc_tx_framer dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .TxEN          (TxEN),
    .Tx_Data       (Tx_Data),
    .Tx_DataValid  (Tx_DataValid),
    .Tx_DataLast   (Tx_DataLast),
    .Tx_DataReady  (Tx_DataReady),
    .Tx_AbortFrame (Tx_AbortFrame),
    .Tx            (Tx),
    .Tx_ValidFrame (Tx_ValidFrame),
    .Tx_Done       (Tx_Done),
    .Tx_Aborted    (Tx_Aborted),
    .Tx_Underrun   (Tx_Underrun)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compare captured line bits with the model stream.
  task automatic cmp_stream(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] != exp_q[i])) bad = i;
    if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: stream differs at bit %0d, got length %0d expected length %0d", name, bad, got_q.size(), exp_q.size());
    end
  endtask

  function automatic void push_byte_bits(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endfunction

  // Reference: flag + stuffed(payload bits [+ CRC bits]) + flag.
  function automatic void build_expected();
    bit          raw[$];
    logic [15:0] crc;
    logic        fb;
    int          ones;
    exp_q.delete();
    push_byte_bits(8'h7E);
    foreach (pay_q[j]) for (int i = 0; i < 8; i++) raw.push_back(pay_q[j][i]);
`ifdef HDLC_TX_FCS_EN
    crc = 16'h0000;
    foreach (raw[i]) begin
      fb  = raw[i] ^ crc[15];
      crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    for (int i = 15; i >= 0; i--) raw.push_back(crc[i]);
`else
    crc = 16'h0000;
    fb  = crc[0];
`endif
    ones = 0;
    foreach (raw[i]) begin
      exp_q.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    push_byte_bits(8'h7E);
  endfunction

  task automatic push(input logic [7:0] d, input logic last, output bit ok);
    int k;
    k  = 0;
    ok = 1'b0;
    Tx_Data      = d;
    Tx_DataLast  = last;
    Tx_DataValid = 1'b1;
    while (!ok && k < 400) begin
      ok = Tx_DataReady;
      @(posedge Clk);
      #1;
      k++;
    end
    Tx_DataValid = 1'b0;
    Tx_DataLast  = 1'b0;
  endtask

  task automatic send_frame(input bit set_last);
    bit ok;
    for (int i = 0; i < pay_q.size(); i++) begin
      push(pay_q[i], set_last && (i == pay_q.size() - 1), ok);
      chk("byte_accept", {31'd0, ok}, 32'd1);
    end
  endtask

  // Records Tx while Tx_ValidFrame is high and counts pulses through the falling cycle.
  // abort_at > 0 raises Tx_AbortFrame for one cycle after that many bits.
  task automatic capture(input int abort_at);
    int k;
    got_q.delete();
    d_cnt = 0; a_cnt = 0; u_cnt = 0;
    k = 0;
    while (!Tx_ValidFrame && k < 400) begin
      @(negedge Clk);
      k++;
    end
    chk("frame_start", {31'd0, Tx_ValidFrame}, 32'd1);
    if (Tx_ValidFrame) begin
      k = 0;
      while (Tx_ValidFrame && k < 3000) begin
        got_q.push_back(Tx);
        d_cnt += int'(Tx_Done);
        a_cnt += int'(Tx_Aborted);
        u_cnt += int'(Tx_Underrun);
        Tx_AbortFrame = (abort_at > 0 && got_q.size() == abort_at);
        @(negedge Clk);
        k++;
      end
      Tx_AbortFrame = 1'b0;
      d_cnt += int'(Tx_Done);
      a_cnt += int'(Tx_Aborted);
      u_cnt += int'(Tx_Underrun);
      chk("frame_end", {31'd0, Tx_ValidFrame}, 32'd0);
    end
  endtask

  task automatic run_frame(input bit set_last, input int abort_at);
    fork
      send_frame(set_last);
      capture(abort_at);
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    int n;
    logic [7:0] b;

    tbl[0] = '{1, 32'h0000_0001,  8, 32'h0000_0001};
    tbl[1] = '{1, 32'h0000_00FF,  9, 32'h0000_01DF};
    tbl[2] = '{2, 32'h0000_F81F, 18, 32'h0001_F01F};
    tbl[3] = '{1, 32'h0000_007E,  9, 32'h0000_00BE};
    tbl[4] = '{2, 32'h0000_AA55, 16, 32'h0000_AA55};

    Rst = 1'b1; TxEN = 1'b1; Tx_Data = 8'h00; Tx_DataValid = 1'b0;
    Tx_DataLast = 1'b0; Tx_AbortFrame = 1'b0;
    #1 Rst = 1'b0;
    #11;
    chk("rst_tx",       {31'd0, Tx},            32'd1);
    chk("rst_valid",    {31'd0, Tx_ValidFrame}, 32'd0);
    chk("rst_ready",    {31'd0, Tx_DataReady},  32'd0);
    chk("rst_done",     {31'd0, Tx_Done},       32'd0);
    chk("rst_aborted",  {31'd0, Tx_Aborted},    32'd0);
    chk("rst_underrun", {31'd0, Tx_Underrun},   32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("idle_tx",    {31'd0, Tx},           32'd1);
    chk("idle_ready", {31'd0, Tx_DataReady}, 32'd1);

    // Table vectors: fixed payloads with hand-derived stuffed data bits.
    for (int v = 0; v < 5; v++) begin
      pay_q.delete();
      for (int i = 0; i < tbl[v].n; i++) pay_q.push_back(tbl[v].bytes[8*i +: 8]);
      build_expected();
      run_frame(1'b1, 0);
      ok = (got_q.size() >= 8 + tbl[v].dlen);
      for (int i = 0; i < 8 && ok; i++) if (got_q[i] != ((8'h7E >> i) & 8'h01)) ok = 1'b0;
      for (int i = 0; i < tbl[v].dlen && ok; i++) if (got_q[8 + i] != tbl[v].dbits[i]) ok = 1'b0;
      chk($sformatf("vec%0d_flag_data", v), {31'd0, ok}, 32'd1);
`ifndef HDLC_TX_FCS_EN
      chk($sformatf("vec%0d_len", v), got_q.size(), 16 + tbl[v].dlen);
`endif
      chk($sformatf("vec%0d_done", v),    d_cnt, 1);
      chk($sformatf("vec%0d_aborted", v), a_cnt, 0);
      cmp_stream($sformatf("vec%0d_model", v));
      repeat (2) @(negedge Clk);
    end

    // Line stays idle-high after a frame.
    seen = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      if (Tx !== 1'b1 || Tx_ValidFrame !== 1'b0) seen = 1'b0;
    end
    chk("post_frame_idle", {31'd0, seen}, 32'd1);

    // Abort mid-DATA after three data bits.
    pay_q.delete(); pay_q.push_back(8'h00);
    exp_q.delete();
    push_byte_bits(8'h7E);
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
    push_byte_bits(8'hFE);
    run_frame(1'b0, 11);
    cmp_stream("abort_bits");
    chk("abort_pulse",    a_cnt, 1);
    chk("abort_underrun", u_cnt, 0);
    chk("abort_done",     d_cnt, 0);
    seen = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      if (Tx !== 1'b1) seen = 1'b0;
    end
    chk("abort_then_idle", {31'd0, seen}, 32'd1);

    // Underrun: second byte withheld at the byte boundary.
    pay_q.delete(); pay_q.push_back(8'h00);
    exp_q.delete();
    push_byte_bits(8'h7E);
    push_byte_bits(8'h00);
    push_byte_bits(8'hFE);
    run_frame(1'b0, 0);
    cmp_stream("underrun_bits");
    chk("underrun_pulse", u_cnt, 1);
    chk("underrun_abort", a_cnt, 1);
    repeat (2) @(negedge Clk);

    // Ready stays low after Last until the frame is back in IDLE.
    push(8'h01, 1'b1, ok);
    chk("last_accept", {31'd0, ok}, 32'd1);
    repeat (10) @(negedge Clk);
    chk("rdy_after_last", {31'd0, Tx_DataReady}, 32'd0);
    seen = 1'b0; n = 0;
    while (!seen && n < 60) begin
      @(negedge Clk);
      seen = Tx_Done;
      n++;
    end
    chk("last_done_seen", {31'd0, seen}, 32'd1);
    chk("rdy_in_idle",    {31'd0, Tx_DataReady}, 32'd1);

    // TxEN dropped mid-frame behaves as an abort.
    push(8'h00, 1'b0, ok);
    repeat (12) @(negedge Clk);
    TxEN = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge Clk);
      seen = Tx_Aborted;
      n++;
    end
    chk("txen_abort", {31'd0, seen}, 32'd1);
    TxEN = 1'b1;
    repeat (2) @(negedge Clk);

    // Asynchronous reset mid-frame.
    push(8'h00, 1'b0, ok);
    repeat (10) @(negedge Clk);
    chk("pre_rst_tx",    {31'd0, Tx},            32'd0);
    chk("pre_rst_valid", {31'd0, Tx_ValidFrame}, 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("async_rst_tx",    {31'd0, Tx},            32'd1);
    chk("async_rst_valid", {31'd0, Tx_ValidFrame}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    seen = 1'b1;
    repeat (12) begin
      @(negedge Clk);
      if (Tx !== 1'b1 || Tx_ValidFrame !== 1'b0 || Tx_Aborted !== 1'b0) seen = 1'b0;
    end
    chk("rst_no_abort", {31'd0, seen}, 32'd1);

    // Randomized frames, some back-to-back.
    for (int f = 0; f < 30; f++) begin
      pay_q.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        pay_q.push_back(b);
      end
      build_expected();
      run_frame(1'b1, 0);
      cmp_stream($sformatf("rand%0d", f));
      chk($sformatf("rand%0d_done", f), d_cnt, 1);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_framer.md
# hdlc_tx_framer

Serial HDLC transmit framer: accepts payload bytes over a valid/ready handshake and drives the single-bit `Tx` line. It emits the opening flag, then the payload LSB first with zero insertion, then an optional FCS, then the closing flag. It also generates the idle pattern and the abort pattern. It sits between the Tx buffer/controller and the serial line, as the counterpart of the Rx deframer.

## Interface

**Parameters**
- `FLAG`, 8'h7E: flag pattern, sent LSB first.
- `ABORT`, 8'hFE: abort pattern, sent LSB first (one 0, then seven 1s).

**Ports**
- `Clk`  in  1: clock; one line bit per cycle.
- `Rst`  in  1: asynchronous, active-low reset.
- `TxEN`  in  1: transmitter enable.
- `Tx_Data`  in  8: payload byte.
- `Tx_DataValid`  in  1: `Tx_Data` is valid.
- `Tx_DataLast`  in  1: qualifies `Tx_Data` as the final payload byte.
- `Tx_DataReady`  out  1: framer accepts a byte this cycle.
- `Tx_AbortFrame`  in  1: request to abort the current frame.
- `Tx`  out  1: serial line output (registered).
- `Tx_ValidFrame`  out  1: high while flag, data, FCS or abort bits are on `Tx`.
- `Tx_Done`  out  1: one-cycle pulse after the last closing-flag bit.
- `Tx_Aborted`  out  1: one-cycle pulse after the last abort bit.
- `Tx_Underrun`  out  1: one-cycle pulse when a frame is aborted because no byte was available.

## Operation

**Reset values**
- `Tx`=1.
- `Tx_ValidFrame`, `Tx_DataReady`, `Tx_Done`, `Tx_Aborted`, `Tx_Underrun` = 0.
- State = IDLE, CRC = 0, stuff counter = 0, holding register empty.

**Byte handshake**
- A transfer occurs when `Tx_DataValid && Tx_DataReady`.
- There is a one-byte holding register. `Tx_DataReady` = `TxEN` && holding register empty && state ∈ {IDLE, SFLAG, DATA}.
- After `Tx_DataLast` is accepted, `Tx_DataReady` stays low until the frame returns to IDLE.

**State machine**
- IDLE:
  - `Tx`=1.
  - Go to SFLAG on a transfer.
- SFLAG: shift out `FLAG` for 8 cycles, then go to DATA.
- DATA:
  - Shift out the byte LSB first.
  - At each byte boundary, load the next byte from the holding register.
  - After the last byte, go to FCS (macro defined) or EFLAG.
  - If the holding register is empty at a byte boundary: go to ABRT and pulse `Tx_Underrun`.
- FCS: shift out 16 CRC bits, crc[15] first, then go to EFLAG.
- EFLAG: shift out `FLAG` for 8 cycles, pulse `Tx_Done`, then go to IDLE.
- ABRT: shift out `ABORT` for 8 cycles, pulse `Tx_Aborted`, then go to IDLE.

**Zero insertion**
- Applies to DATA and FCS bits only, never to flag or abort bits.
- The counter counts consecutive 1s driven on `Tx`. It clears on any 0 and on entry to DATA.
- After five consecutive 1s, the next cycle drives 0, stalls the shifter and clears the counter.
- The counter persists across byte boundaries and across the DATA→FCS transition.

**FCS arithmetic**
- Computed over unstuffed payload bits in transmission order.
- Per bit: `fb = d ^ crc[15]; crc = {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 0)`.
- The CRC is cleared in SFLAG.

**Abort and enable**
- `Tx_AbortFrame` sampled high in SFLAG, DATA or FCS: go to ABRT; the first abort bit appears on `Tx` in the next cycle.
- `Tx_AbortFrame` is ignored in IDLE, EFLAG and ABRT.
- `TxEN` low in SFLAG, DATA or FCS is treated as an abort.
- Abort and `Tx_DataLast` in the same cycle: abort wins.
- Abort flushes the holding register.

## Timing

- Transfer in IDLE at cycle n: `Tx_ValidFrame`=1 and the first flag bit (0) is on `Tx` at n+1.
- `Tx_ValidFrame` rises with the first SFLAG bit and falls the cycle after the last EFLAG/ABRT bit. `Tx_Done` or `Tx_Aborted` is high in that same cycle.
- Frame length in cycles = 16 + 8·bytes + (16 with FCS) + stuffed zeros.
- Back-to-back frames: a new transfer is accepted in the first IDLE cycle. No other minimum idle gap applies.
- Asynchronous reset mid-frame: `Tx` returns to 1 immediately; no abort is sent.

## Configuration

- `HDLC_TX_FCS_EN`:
  - Defined: FCS state and CRC logic are compiled in; 16 FCS bits are sent before the closing flag.
  - Undefined: no CRC logic; DATA goes directly to EFLAG.

## Test plan

- Build with macro undefined. Single byte 0x01 with Last → `Tx` = 01111110, 10000000, 01111110; `Tx_Done` pulses once; then `Tx`=1 continuously.
- Build with macro undefined. Single byte 0xFF → data bits 11111 0 111 (one stuffed 0); total frame 25 cycles.
- Bytes 0x1F, 0xF8 → stuffing spans the byte boundary: 11111 0 000 000 11111 0 (two zeros inserted).
- Build with macro defined. Bytes 0x12, 0x34 → checker CRC over received data+FCS bits (unstuffed) = 16'h0000; 16 FCS bits appear between data and closing flag.
- Assert `Tx_AbortFrame` mid-DATA → next 8 bits are 0,1111111; `Tx_Aborted` pulses; `Tx_ValidFrame` falls; `Tx` then stays 1.
- Withhold the second byte at the boundary → `Tx_Underrun` and `Tx_Aborted` each pulse once. Assert `Rst` mid-frame → `Tx`=1 and `Tx_ValidFrame`=0 asynchronously.
